// File: rtl/key_event_decoder_if.sv
// Key event bus: debounced key level in, event pulses, held flag and press count out.
interface key_event_decoder_if;
  logic       key_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  logic       key_held;
  logic [7:0] press_cnt;

  modport master (
    output key_level,
    input  press_pulse, release_pulse, long_pulse, repeat_pulse, key_held, press_cnt
  );

  modport slave (
    input  key_level,
    output press_pulse, release_pulse, long_pulse, repeat_pulse, key_held, press_cnt
  );
endinterface

// File: rtl/key_event_decoder.sv
// Turns a debounced key level into press/release/long/repeat pulses, a held flag and a press counter.
// Optional feature macro: KEY_REPEAT_EN enables auto-repeat pulses while in long hold.
module key_event_decoder #(
  parameter int LONG_TIME   = 100_000_000,
  parameter int REPEAT_TIME = 20_000_000,
  parameter int CNT_W       = 27
) (
  input  logic                clk,
  input  logic                rst_n,
  key_event_decoder_if.slave  key_if
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHORT = 2'd1,
    ST_LONG  = 2'd2
  } state_e;

`ifdef KEY_REPEAT_EN
  localparam logic REPEAT_ON = 1'b1;
`else
  localparam logic REPEAT_ON = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TIME - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TIME - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]       press_cnt_q, press_cnt_d;
  logic             press_pulse_q, press_pulse_d;
  logic             release_pulse_q, release_pulse_d;
  logic             long_pulse_q, long_pulse_d;
  logic             repeat_pulse_q, repeat_pulse_d;
  logic             key_held_q, key_held_d;

  // Next-state and next-output decode; a low key always wins over any threshold.
  always_comb begin
    state_d         = state_q;
    hold_cnt_d      = hold_cnt_q;
    press_cnt_d     = press_cnt_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    long_pulse_d    = 1'b0;
    repeat_pulse_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_if.key_level) begin
          state_d       = ST_SHORT;
          hold_cnt_d    = '0;
          press_cnt_d   = press_cnt_q + 8'd1;
          press_pulse_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHORT: begin
        if (!key_if.key_level) begin
          state_d         = ST_IDLE;
          hold_cnt_d      = '0;
          release_pulse_d = 1'b1;
        end else if (hold_cnt_q == LONG_LAST) begin
          state_d      = ST_LONG;
          hold_cnt_d   = '0;
          long_pulse_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_LONG: begin
        if (!key_if.key_level) begin
          state_d         = ST_IDLE;
          hold_cnt_d      = '0;
          release_pulse_d = 1'b1;
        end else if (!REPEAT_ON) begin
          // Without auto-repeat the counter parks until release.
          hold_cnt_d = hold_cnt_q;
        end else if (hold_cnt_q == REPEAT_LAST) begin
          hold_cnt_d     = '0;
          repeat_pulse_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        hold_cnt_d = '0;
      end
    endcase
    key_held_d = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      hold_cnt_q      <= '0;
      press_cnt_q     <= 8'd0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_pulse_q    <= 1'b0;
      repeat_pulse_q  <= 1'b0;
      key_held_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      hold_cnt_q      <= hold_cnt_d;
      press_cnt_q     <= press_cnt_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      long_pulse_q    <= long_pulse_d;
      repeat_pulse_q  <= repeat_pulse_d;
      key_held_q      <= key_held_d;
    end
  end

  assign key_if.press_pulse   = press_pulse_q;
  assign key_if.release_pulse = release_pulse_q;
  assign key_if.long_pulse    = long_pulse_q;
  assign key_if.repeat_pulse  = repeat_pulse_q;
  assign key_if.key_held      = key_held_q;
  assign key_if.press_cnt     = press_cnt_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder with LONG_TIME=8, REPEAT_TIME=4.
module tb_key_event_decoder;

  localparam int LONG_T = 8;
  localparam int REP_T  = 4;
`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk_r   = 1'b0;
  logic rst_n_r = 1'b1;

  key_event_decoder_if key_if ();

  key_event_decoder #(
    .LONG_TIME   (LONG_T),
    .REPEAT_TIME (REP_T),
    .CNT_W       (27)
  ) dut (
    .clk    (clk_r),
    .rst_n  (rst_n_r),
    .key_if (key_if.slave)
  );

  always #5 clk_r = ~clk_r;

  int         tests_run_r    = 0;
  int         tests_failed_r = 0;
  string      phase_r        = "init";
  logic [12:0] exp_q[$];

  // Reference model: counts consecutive high samples since the press edge.
  bit         m_active_r = 1'b0;
  int         m_n_r      = 0;
  logic [7:0] m_cnt_r    = 8'd0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run_r++;
    if (obs !== exp) begin
      tests_failed_r++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h at %0t", phase_r, tag, obs, exp, $time);
    end
  endtask

  function automatic logic [12:0] obs_vec();
    return {key_if.press_pulse, key_if.release_pulse, key_if.long_pulse,
            key_if.repeat_pulse, key_if.key_held, key_if.press_cnt};
  endfunction

  task automatic model_step(input logic k, output logic [12:0] e);
    logic p, r, l, rp;
    p = 1'b0; r = 1'b0; l = 1'b0; rp = 1'b0;
    if (!m_active_r) begin
      if (k) begin
        m_active_r = 1'b1;
        m_n_r      = 0;
        m_cnt_r    = m_cnt_r + 8'd1;
        p          = 1'b1;
      end
    end else if (!k) begin
      m_active_r = 1'b0;
      r          = 1'b1;
    end else begin
      m_n_r++;
      if (m_n_r == LONG_T) l = 1'b1;
      else if (REP_EN && m_n_r > LONG_T && ((m_n_r - LONG_T) % REP_T) == 0) rp = 1'b1;
    end
    e = {p, r, l, rp, m_active_r, m_cnt_r};
  endtask

  // Drive one sampled key value, push its expectation, compare after the edge.
  task automatic drive_cycle(input logic k);
    logic [12:0] e;
    key_if.key_level = k;
    model_step(k, e);
    exp_q.push_back(e);
    @(posedge clk_r);
    #1;
    check_eq("cycle", {19'd0, obs_vec()}, {19'd0, exp_q.pop_front()});
  endtask

  task automatic drive_run(input logic k, input int n);
    for (int i = 0; i < n; i++) drive_cycle(k);
  endtask

  task automatic apply_reset(input logic k, input int cycles);
    key_if.key_level = k;
    rst_n_r          = 1'b0;
    m_active_r       = 1'b0;
    m_n_r            = 0;
    m_cnt_r          = 8'd0;
    #1;
    check_eq("rst_async", {19'd0, obs_vec()}, 32'd0);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_r);
      #1;
      check_eq("rst_hold", {19'd0, obs_vec()}, 32'd0);
    end
    @(negedge clk_r);
    rst_n_r = 1'b1;
  endtask

  initial begin
    key_if.key_level = 1'b0;
    #2;
    phase_r = "reset";
    apply_reset(1'b0, 3);
    drive_run(1'b0, 2);

    phase_r = "short";
    drive_run(1'b1, 3);
    drive_run(1'b0, 3);
    check_eq("short_cnt", {24'd0, key_if.press_cnt}, 32'd1);

    phase_r = "long";
    drive_run(1'b1, 20);
    drive_run(1'b0, 3);

    phase_r = "edge_release";
    drive_run(1'b1, LONG_T);
    drive_run(1'b0, 3);

    phase_r = "repress";
    drive_cycle(1'b1);
    drive_cycle(1'b0);
    drive_cycle(1'b1);
    drive_cycle(1'b0);
    drive_run(1'b0, 2);

    phase_r = "wrap";
    apply_reset(1'b0, 1);
    for (int i = 0; i < 257; i++) begin
      drive_cycle(1'b1);
      drive_cycle(1'b0);
    end
    check_eq("wrap_cnt", {24'd0, key_if.press_cnt}, 32'd1);

    phase_r = "rst_mid_long";
    drive_run(1'b0, 2);
    drive_run(1'b1, 12);
    apply_reset(1'b1, 2);
    drive_cycle(1'b1);
    check_eq("rst_press", {31'd0, key_if.press_pulse}, 32'd1);
    check_eq("rst_press_cnt", {24'd0, key_if.press_cnt}, 32'd1);
    drive_run(1'b1, 3);
    drive_run(1'b0, 3);

    $display("[TB] %0d tests run, %0d failed", tests_run_r, tests_failed_r);
    $finish;
  end

endmodule
